// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: byte-addressable little-endian data
// memory with sized loads/stores, and the registered MEM/WB pipeline outputs.

module memory_access_lane #(
    parameter int NB_IDX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [NB_IDX-1:0] idx,
    input  logic [7:0]        wbyte,
    input  logic [NB_IDX-1:0] dbg_idx,
    output logic [7:0]        rbyte,
    output logic [7:0]        dbg_byte
);
    localparam int DEPTH = 2 ** NB_IDX;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= wbyte;
        end
    end

    assign rbyte    = mem[idx];
    assign dbg_byte = mem[dbg_idx];
endmodule

module memory_access #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_mem2Reg,
    input  logic               i_regWrite,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_ADDR-3:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_word,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_alu_result
);
    localparam int NUM_LANES = NB_DATA / 8;

    logic [NB_ADDR-1:0]                addr;
    logic [NB_ADDR-3:0]                idx;
    logic [NUM_LANES-1:0]              byte_en;
    logic [NUM_LANES-1:0][7:0]         wdata;
    logic [NUM_LANES-1:0][7:0]         rword;
    logic [NUM_LANES-1:0][7:0]         dbg_word;
    logic [7:0]                        ld_byte;
    logic [15:0]                       ld_half;
    logic [NB_DATA-1:0]                ld_ext;
    logic                              unused_addr_hi;

    assign addr = i_alu_result[NB_ADDR-1:0];
    assign idx  = addr[NB_ADDR-1:2];

    // Upper address bits are discarded so accesses wrap modulo 2**NB_ADDR.
    assign unused_addr_hi = ^i_alu_result[NB_DATA-1:NB_ADDR];

    // Store data is replicated across lanes; byte enables pick the target.
    always_comb begin
        byte_en = '0;
        wdata   = i_data4Mem;
        case (i_width)
            2'b00: begin
                byte_en = NUM_LANES'(1) << addr[1:0];
                wdata   = {NUM_LANES{i_data4Mem[7:0]}};
            end
            2'b01: begin
                byte_en = addr[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{i_data4Mem[15:0]}};
            end
            default: begin
                byte_en = '1;
                wdata   = i_data4Mem;
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            memory_access_lane #(.NB_IDX(NB_ADDR-2)) u_lane (
                .clk      (clk),
                .rst_n    (i_rst_n),
                .we       (i_memWrite && !i_halt && byte_en[g]),
                .idx      (idx),
                .wbyte    (wdata[g]),
                .dbg_idx  (i_dbg_addr),
                .rbyte    (rword[g]),
                .dbg_byte (dbg_word[g])
            );
        end
    endgenerate

    assign o_dbg_word = dbg_word;

    // Read path sees the pre-store word, so a simultaneous load returns old data.
    always_comb begin
        ld_byte = rword[addr[1:0]];
        ld_half = addr[1] ? rword[3:2] : rword[1:0];
        case (i_width)
            2'b00:   ld_ext = {{(NB_DATA-8){i_sign_flag & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{(NB_DATA-16){i_sign_flag & ld_half[15]}}, ld_half};
            default: ld_ext = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_write_reg  <= '0;
            o_read_data  <= '0;
            o_alu_result <= '0;
        end else if (!i_halt) begin
            o_mem2reg    <= i_mem2Reg;
            o_regWrite   <= i_regWrite;
            o_write_reg  <= i_write_reg;
            o_read_data  <= i_memRead ? ld_ext : '0;
            o_alu_result <= i_alu_result;
        end
    end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM pipeline register: ALU result, store data, width, sign and control flags, and destination register.
- Holds a byte-addressable, little-endian data memory. Performs sized loads and stores, and registers the MEM/WB pipeline outputs consumed by write-back and by the forwarding unit.

Parameters:
NB_DATA, 32, data path width in bits
NB_ADDR, 10, byte-address bits used to index data memory (depth = 2**(NB_ADDR-2) words)

Ports:
clk  in  1  system clock, all state updates on rising edge
i_rst_n  in  1  synchronous active-low reset
i_halt  in  1  freezes all state (memory and MEM/WB outputs hold)
i_alu_result  in  NB_DATA  EX/MEM ALU result; byte address for load/store
i_data4Mem  in  NB_DATA  EX/MEM store data (right-aligned)
i_width  in  2  access size: 00 byte, 01 halfword, 10/11 word
i_sign_flag  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
i_memRead  in  1  load enable
i_memWrite  in  1  store enable
i_mem2Reg  in  1  EX/MEM write-back select, passed through
i_regWrite  in  1  EX/MEM register write enable, passed through
i_write_reg  in  5  EX/MEM destination register, passed through
i_dbg_addr  in  NB_ADDR-2  debug word index
o_dbg_word  out  NB_DATA  combinational debug read of memory word i_dbg_addr
o_mem2reg  out  1  MEM/WB write-back select (1 = load data)
o_regWrite  out  1  MEM/WB register write enable
o_write_reg  out  5  MEM/WB destination register
o_read_data  out  NB_DATA  MEM/WB extended load data
o_alu_result  out  NB_DATA  MEM/WB copy of ALU result

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is synchronous, active-low: sampled on a rising edge of clk when i_rst_n=0.

Reset values:
- All outputs: o_mem2reg=0, o_regWrite=0, o_write_reg=0, o_read_data=0, o_alu_result=0.
- Every memory word is cleared to 0.
- Reset overrides i_halt and any store in the same cycle.

Addressing:
- addr = i_alu_result[NB_ADDR-1:0]. Upper bits are ignored, so addresses wrap modulo 2**NB_ADDR.
- word index = addr[NB_ADDR-1:2].
- Byte lane = addr[1:0]; halfword lane = addr[1], with addr[0] ignored; word access ignores addr[1:0].
- No misalignment exception is raised.

Store (i_memWrite=1, !i_halt):
- Write occurs on the rising edge.
- Byte: i_data4Mem[7:0] is written to the selected lane.
- Halfword: i_data4Mem[15:0] is written to the selected half.
- Word: the full word is written.
- Unselected bytes of the word are unchanged.

Load:
- The memory word is read combinationally, then the addressed lane is extracted and right-aligned.
- Byte and halfword loads are extended per i_sign_flag.
- The result is registered into o_read_data. Latency is 1 cycle from EX/MEM inputs to MEM/WB outputs.
- When i_memRead=0, o_read_data is loaded with 0.

Pass-through:
- o_mem2reg, o_regWrite, o_write_reg and o_alu_result register their inputs each non-halted cycle.

Halt:
- When i_halt=1: no memory write, and all MEM/WB outputs hold their previous values.
- Deasserting halt resumes on the next edge with no lost or repeated store.

Simultaneous read and write:
- If i_memRead and i_memWrite are both 1 (illegal from decode), the store is performed.
- o_read_data captures the pre-store contents.

Debug port:
- o_dbg_word reflects the current array contents, including a store completed on the preceding edge.
- It is independent of i_halt.

Reset mid-operation:
- Any pending store in the reset cycle is discarded.
- Outputs are zero on the following cycle.

Test Plan:
1. Reset with stale memory data -> all outputs 0; o_dbg_word=0 for word indices 0, 1 and 255.
2. Word store 0xDEADBEEF at addr 0x008, then word load at 0x008 -> o_read_data=0xDEADBEEF one cycle after the load inputs; o_dbg_word(idx 2)=0xDEADBEEF.
3. Memory word 0 = 0x80F17F01. Signed byte load at addr 1 -> 0x0000007F. Signed byte load at addr 3 -> 0xFFFFFF80. Unsigned byte load at addr 3 -> 0x00000080. Signed halfword load at addr 2 -> 0xFFFF80F1.
4. Word 0 = 0x11223344. Byte store 0xAA at addr 2 -> word becomes 0x11AA3344. Halfword store 0xBEEF at addr 0 -> word becomes 0x11AABEEF.
5. i_halt=1 while a word store of 0x12345678 is presented at addr 0x010 with i_regWrite=1, i_write_reg=5 -> memory word 4 is unchanged and outputs hold their previous values. Release halt -> store lands and o_write_reg=5.
6. Address wrap: word store 0xCAFEF00D with i_alu_result=0x00000404 (NB_ADDR=10) -> word index 1 is written. Same store with reset asserted in that cycle -> word index 1 stays 0.
